// File: rtl/gen_fram_param_pkg.sv
// Shared types and block constants for the 64b/66b test-frame generator.
package gen_fram_pkg;

   localparam int unsigned SYNC_W      = 2;
   localparam int unsigned PAYLOAD_W   = 64;
   localparam int unsigned FRAME_CNT_W = 32;
   localparam int unsigned BLK_CNT_W   = 8;
   localparam int unsigned LFSR_W      = 31;

   localparam logic [SYNC_W-1:0] SYNC_DATA = 2'b01;
   localparam logic [SYNC_W-1:0] SYNC_CTRL = 2'b10;

   typedef struct packed {
      logic [SYNC_W-1:0]    sync;
      logic [PAYLOAD_W-1:0] payload;
   } blk_t;

   localparam blk_t BLK_SOF  = '{sync: SYNC_CTRL, payload: 64'hd555555555555578};
   localparam blk_t BLK_EOF  = '{sync: SYNC_CTRL, payload: 64'h0000000000000087};
   localparam blk_t BLK_IDLE = '{sync: SYNC_CTRL, payload: 64'h000000000000001e};

   localparam logic [LFSR_W-1:0] PRBS_SEED = 31'h7FFF_FFFF;

   // State names the block currently presented on dat_o.
   typedef enum logic [2:0] {IDLE, SOF, DATA, EOF, GAP, DONE} state_t;

   // Counter payload: frame number in the top word, block index in the low byte.
   function automatic blk_t data_blk(input logic [FRAME_CNT_W-1:0] f,
                                     input logic [BLK_CNT_W-1:0]   k);
      return '{sync: SYNC_DATA, payload: {f, 24'h0, k}};
   endfunction

endpackage

// File: rtl/gen_fram_param_if.sv
// Block stream with valid/ready handshake between the generator and its sink.
interface gen_fram_param_if;
   import gen_fram_pkg::*;

   blk_t dat_o;
   logic dat_vld;
   logic dat_rdy;

   modport master (output dat_o, output dat_vld, input dat_rdy);
   modport slave  (input dat_o, input dat_vld, output dat_rdy);

endinterface

// File: rtl/gen_fram_param_prbs31.sv
// PRBS31 (x^31+x^28+1) advanced 64 serial steps per call; bit 63 is the first bit.
// Only compiled when GEN_FRAM_PRBS_EN is defined.
`ifdef GEN_FRAM_PRBS_EN
module prbs31_par64
   import gen_fram_pkg::*;
(
   input  logic [LFSR_W-1:0]    i_state,
   output logic [LFSR_W-1:0]    o_state,
   output logic [PAYLOAD_W-1:0] o_data
);

   logic [LFSR_W-1:0] w_s;
   logic              w_b;

   // s[0] is the newest bit; each step feeds back s[30]^s[27].
   always_comb begin
      w_s    = i_state;
      w_b    = 1'b0;
      o_data = '0;
      for (int i = 0; i < int'(PAYLOAD_W); i++) begin
         w_b                          = w_s[30] ^ w_s[27];
         o_data[int'(PAYLOAD_W)-1-i]  = w_b;
         w_s                          = {w_s[LFSR_W-2:0], w_b};
      end
      o_state = w_s;
   end

endmodule
`endif

// File: rtl/gen_fram_param.sv
// Parametrised 64b/66b test-frame source: SOF, data blocks, EOF, idle gap, repeat.
// Define GEN_FRAM_PRBS_EN for PRBS31 payload instead of the frame/block counter payload.
module gen_fram_param
   import gen_fram_pkg::*;
#(
   parameter int unsigned PAYLOAD_BLKS = 8,
   parameter int unsigned GAP_BLKS     = 12,
   parameter int unsigned FRAME_NUM    = 0
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   gen_fram_param_if.master       bus,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   busy,
   output logic                   done
);

   localparam logic [BLK_CNT_W-1:0]   LAST_BLK  = BLK_CNT_W'(PAYLOAD_BLKS - 1);
   localparam logic [BLK_CNT_W-1:0]   LAST_GAP  = BLK_CNT_W'(GAP_BLKS - 1);
   localparam logic [FRAME_CNT_W-1:0] FRAME_LIM = FRAME_CNT_W'(FRAME_NUM);

   state_t                 r_state;
   blk_t                   r_dat;
   logic                   r_vld;
   logic                   r_busy;
   logic                   r_done;
   logic [FRAME_CNT_W-1:0] r_frame_cnt;
   logic [BLK_CNT_W-1:0]   r_blk_cnt;
   logic [BLK_CNT_W-1:0]   r_gap_cnt;

   logic                   w_acc;
   logic                   w_end_frame;
   logic                   w_stop;
   logic [FRAME_CNT_W-1:0] w_fc_upd;
   state_t                 w_dec_state;
   blk_t                   w_data_blk;

   assign w_acc = r_vld & bus.dat_rdy;

   // Frame count as it will be after this cycle; the EOF acceptance bumps it.
   assign w_fc_upd = (r_state == EOF) ? r_frame_cnt + FRAME_CNT_W'(1) : r_frame_cnt;
   assign w_stop   = (FRAME_NUM != 0) && (w_fc_upd == FRAME_LIM);

   assign w_end_frame = w_acc & (((r_state == EOF) && (GAP_BLKS == 0)) ||
                                 ((r_state == GAP) && (r_gap_cnt == LAST_GAP)));

   always_comb begin
      w_dec_state = IDLE;
      if (w_stop)  w_dec_state = DONE;
      else if (en) w_dec_state = SOF;
   end

`ifdef GEN_FRAM_PRBS_EN
   logic [LFSR_W-1:0]    r_lfsr;
   logic [LFSR_W-1:0]    w_lfsr_nxt;
   logic [PAYLOAD_W-1:0] w_prbs;
   logic                 w_load_data;

   prbs31_par64 u_prbs (
      .i_state (r_lfsr),
      .o_state (w_lfsr_nxt),
      .o_data  (w_prbs)
   );

   assign w_load_data = w_acc & ((r_state == SOF) ||
                                 ((r_state == DATA) && (r_blk_cnt != LAST_BLK)));
   assign w_data_blk  = '{sync: SYNC_DATA, payload: w_prbs};

   // Sequence runs on across frames; only reset reseeds it.
   always_ff @(posedge clk) begin
      if (rst)              r_lfsr <= PRBS_SEED;
      else if (w_load_data) r_lfsr <= w_lfsr_nxt;
   end
`else
   logic [BLK_CNT_W-1:0] w_next_k;

   assign w_next_k   = (r_state == SOF) ? '0 : r_blk_cnt + BLK_CNT_W'(1);
   assign w_data_blk = data_blk(r_frame_cnt, w_next_k);
`endif

   // Frame sequencer; dat_o/dat_vld only change on acceptance or from IDLE/DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_dat       <= '0;
         r_vld       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_frame_cnt <= '0;
         r_blk_cnt   <= '0;
         r_gap_cnt   <= '0;
      end else if (w_end_frame) begin
         r_frame_cnt <= w_fc_upd;
         r_state     <= w_dec_state;
         r_vld       <= (w_dec_state == SOF);
         r_busy      <= (w_dec_state != IDLE);
         r_done      <= (w_dec_state == DONE);
         if (w_dec_state == SOF) r_dat <= BLK_SOF;
      end else begin
         case (r_state)
            IDLE: begin
               if (en) begin
                  r_state <= SOF;
                  r_dat   <= BLK_SOF;
                  r_vld   <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            SOF: begin
               if (w_acc) begin
                  r_state   <= DATA;
                  r_blk_cnt <= '0;
                  r_dat     <= w_data_blk;
               end
            end
            DATA: begin
               if (w_acc) begin
                  if (r_blk_cnt == LAST_BLK) begin
                     r_state <= EOF;
                     r_dat   <= BLK_EOF;
                  end else begin
                     r_blk_cnt <= r_blk_cnt + BLK_CNT_W'(1);
                     r_dat     <= w_data_blk;
                  end
               end
            end
            EOF: begin
               // Only reached with a non-empty gap; the no-gap case ends the frame above.
               if (w_acc) begin
                  r_frame_cnt <= w_fc_upd;
                  r_state     <= GAP;
                  r_gap_cnt   <= '0;
                  r_dat       <= BLK_IDLE;
               end
            end
            GAP: begin
               if (w_acc) r_gap_cnt <= r_gap_cnt + BLK_CNT_W'(1);
            end
            DONE: begin
               if (!en) begin
                  r_state     <= IDLE;
                  r_frame_cnt <= '0;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_vld   <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dat_o   = r_dat;
   assign bus.dat_vld = r_vld;
   assign frame_cnt   = r_frame_cnt;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_gen_fram_param.sv
// Self-checking bench for gen_fram_param: three parameterisations, directed and random traffic.
module tb_gen_fram_param;

   localparam logic [65:0] B_SOF  = {2'b10, 64'hd555555555555578};
   localparam logic [65:0] B_EOF  = {2'b10, 64'h0000000000000087};
   localparam logic [65:0] B_IDLE = {2'b10, 64'h000000000000001e};

   logic        clk = 1'b0;
   logic        rst;
   logic        a_en, b_en, c_en;
   logic [31:0] a_fc, b_fc, c_fc;
   logic        a_busy, b_busy, c_busy;
   logic        a_done, b_done, c_done;

   int n_chk = 0;
   int n_err = 0;

   gen_fram_param_if a_if ();
   gen_fram_param_if b_if ();
   gen_fram_param_if c_if ();

   gen_fram_param #(.PAYLOAD_BLKS(2), .GAP_BLKS(1), .FRAME_NUM(0)) u_a (
      .clk(clk), .rst(rst), .en(a_en), .bus(a_if),
      .frame_cnt(a_fc), .busy(a_busy), .done(a_done));

   gen_fram_param #(.PAYLOAD_BLKS(3), .GAP_BLKS(0), .FRAME_NUM(0)) u_b (
      .clk(clk), .rst(rst), .en(b_en), .bus(b_if),
      .frame_cnt(b_fc), .busy(b_busy), .done(b_done));

   gen_fram_param #(.PAYLOAD_BLKS(2), .GAP_BLKS(2), .FRAME_NUM(2)) u_c (
      .clk(clk), .rst(rst), .en(c_en), .bus(c_if),
      .frame_cnt(c_fc), .busy(c_busy), .done(c_done));

   always #5 clk = ~clk;

`ifdef GEN_FRAM_PRBS_EN
   logic prbs_bits [0:16383];

   // b[n] = b[n-31] ^ b[n-28], with every bit before the start equal to 1.
   task automatic fill_prbs();
      for (int n = 0; n < 16384; n++) begin
         logic x31, x28;
         x31 = (n >= 31) ? prbs_bits[n-31] : 1'b1;
         x28 = (n >= 28) ? prbs_bits[n-28] : 1'b1;
         prbs_bits[n] = x31 ^ x28;
      end
   endtask
`endif

   function automatic logic [63:0] data_word(int f, int k, int gidx);
`ifdef GEN_FRAM_PRBS_EN
      logic [63:0] w;
      w = '0;
      if (gidx >= 0 && gidx < 256)
         for (int j = 0; j < 64; j++) w[63-j] = prbs_bits[64*gidx + j];
      return w;
`else
      return {32'(f), 24'h0, 8'(k)};
`endif
   endfunction

   // n-th block of an uninterrupted stream (en held high, nothing reset).
   function automatic logic [65:0] model_blk(int p, int g, int n);
      int len, f, i;
      len = p + 2 + g;
      f   = n / len;
      i   = n % len;
      if (i == 0)      return B_SOF;
      else if (i <= p) return {2'b01, data_word(f, i - 1, f * p + i - 1)};
      else if (i == p + 1) return B_EOF;
      else             return B_IDLE;
   endfunction

   task automatic chk(string name, logic [65:0] act, logic [65:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        en;
      logic        vld;
      logic [65:0] dat;
      logic [31:0] fc;
      logic        busy;
   } vec_t;

   vec_t tbl [7];
   int   n;
   logic drained;

   initial begin
`ifdef GEN_FRAM_PRBS_EN
      fill_prbs();
`endif
      rst = 1'b1;
      a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
      a_if.dat_rdy = 1'b0; b_if.dat_rdy = 1'b0; c_if.dat_rdy = 1'b0;
      step(); step();

      chk("rst_vld",  66'(a_if.dat_vld), 66'(0));
      chk("rst_dat",  66'(a_if.dat_o),   66'(0));
      chk("rst_fc",   66'(a_fc),         66'(0));
      chk("rst_busy", 66'(a_busy),       66'(0));
      chk("rst_done", 66'(c_done),       66'(0));
      rst = 1'b0;
      step();

      // Single en pulse, full-rate sink: one frame plus one gap block, then idle.
      tbl[0] = '{1'b1, 1'b1, B_SOF,                               32'd0, 1'b1};
      tbl[1] = '{1'b0, 1'b1, {2'b01, data_word(0, 0, 0)},        32'd0, 1'b1};
      tbl[2] = '{1'b0, 1'b1, {2'b01, data_word(0, 1, 1)},        32'd0, 1'b1};
      tbl[3] = '{1'b0, 1'b1, B_EOF,                               32'd0, 1'b1};
      tbl[4] = '{1'b0, 1'b1, B_IDLE,                              32'd1, 1'b1};
      tbl[5] = '{1'b0, 1'b0, 66'(0),                              32'd1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 66'(0),                              32'd1, 1'b0};
      a_if.dat_rdy = 1'b1;
      for (int i = 0; i < 7; i++) begin
         a_en = tbl[i].en;
         step();
         chk($sformatf("tbl%0d_vld", i),  66'(a_if.dat_vld), 66'(tbl[i].vld));
         chk($sformatf("tbl%0d_fc", i),   66'(a_fc),         66'(tbl[i].fc));
         chk($sformatf("tbl%0d_busy", i), 66'(a_busy),       66'(tbl[i].busy));
         if (tbl[i].vld) chk($sformatf("tbl%0d_dat", i), 66'(a_if.dat_o), tbl[i].dat);
      end

      // Backpressure on the second data block of frame 1.
      a_en = 1'b1;
      step();
      chk("bp_sof", 66'(a_if.dat_o), B_SOF);
      a_en = 1'b0;
      step();
      chk("bp_d0", 66'(a_if.dat_o), {2'b01, data_word(1, 0, 2)});
      step();
      chk("bp_d1", 66'(a_if.dat_o), {2'b01, data_word(1, 1, 3)});
      a_if.dat_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp_hold%0d_dat", i), 66'(a_if.dat_o), {2'b01, data_word(1, 1, 3)});
         chk($sformatf("bp_hold%0d_vld", i), 66'(a_if.dat_vld), 66'(1));
      end
      a_if.dat_rdy = 1'b1;
      step();
      chk("bp_eof", 66'(a_if.dat_o), B_EOF);
      step();
      chk("bp_gap", 66'(a_if.dat_o), B_IDLE);
      step();
      chk("bp_end_vld", 66'(a_if.dat_vld), 66'(0));
      chk("bp_end_fc",  66'(a_fc),         66'(2));

      // Back-to-back frames: EOF followed directly by the next SOF.
      b_en = 1'b1;
      b_if.dat_rdy = 1'b1;
      n = 0;
      for (int c = 0; c < 60 && n < 15; c++) begin
         if (b_if.dat_vld) begin
            chk($sformatf("b2b_blk%0d", n), 66'(b_if.dat_o), model_blk(3, 0, n));
            n++;
         end
         step();
      end
      chk("b2b_count",   66'(n),             66'(15));
      chk("b2b_fc",      66'(b_fc),          66'(3));
      chk("b2b_nextsof", 66'(b_if.dat_o),    B_SOF);
      chk("b2b_nextvld", 66'(b_if.dat_vld),  66'(1));
      b_en = 1'b0;

      // Bounded run of FRAME_NUM=2 frames, then DONE until en drops.
      c_en = 1'b1;
      c_if.dat_rdy = 1'b1;
      n = 0;
      for (int c = 0; c < 80 && !c_done; c++) begin
         if (c_if.dat_vld) begin
            chk($sformatf("fn_blk%0d", n), 66'(c_if.dat_o), model_blk(2, 2, n));
            n++;
         end
         step();
      end
      chk("fn_count", 66'(n),            66'(12));
      chk("fn_done",  66'(c_done),       66'(1));
      chk("fn_vld",   66'(c_if.dat_vld), 66'(0));
      chk("fn_fc",    66'(c_fc),         66'(2));
      chk("fn_busy",  66'(c_busy),       66'(1));
      step();
      chk("fn_hold_done", 66'(c_done),       66'(1));
      chk("fn_hold_vld",  66'(c_if.dat_vld), 66'(0));
      c_en = 1'b0;
      step();
      chk("fn_idle_done", 66'(c_done), 66'(0));
      chk("fn_idle_busy", 66'(c_busy), 66'(0));
      chk("fn_idle_fc",   66'(c_fc),   66'(0));

      // Reset in the middle of a data block aborts the frame.
      a_en = 1'b1;
      step();
      step();
      chk("mid_pre_dat", 66'(a_if.dat_o), {2'b01, data_word(2, 0, 4)});
      rst = 1'b1;
      step();
      chk("mid_rst_vld", 66'(a_if.dat_vld), 66'(0));
      chk("mid_rst_dat", 66'(a_if.dat_o),   66'(0));
      chk("mid_rst_fc",  66'(a_fc),         66'(0));
      rst = 1'b0;
      step();
      chk("mid_restart_vld", 66'(a_if.dat_vld), 66'(1));
      chk("mid_restart_dat", 66'(a_if.dat_o),   B_SOF);

      // Random sink stalls with en held: every presented block must be the model's next one.
      n = 0;
      for (int c = 0; c < 300; c++) begin
         a_if.dat_rdy = ($urandom_range(0, 3) != 0);
         chk("rnd_vld", 66'(a_if.dat_vld), 66'(1));
         chk($sformatf("rnd_blk%0d", n), 66'(a_if.dat_o), model_blk(2, 1, n));
         if (a_if.dat_rdy) n++;
         step();
      end

      // Drop en: the current frame and its gap still complete.
      a_en = 1'b0;
      a_if.dat_rdy = 1'b1;
      drained = 1'b0;
      for (int c = 0; c < 40 && !drained; c++) begin
         if (!a_if.dat_vld) drained = 1'b1;
         else begin
            chk($sformatf("drain_blk%0d", n), 66'(a_if.dat_o), model_blk(2, 1, n));
            n++;
            step();
         end
      end
      chk("drain_stopped", 66'(drained), 66'(1));
      chk("drain_whole",   66'(n % 5),   66'(0));
      chk("drain_fc",      66'(a_fc),    66'(n / 5));
      chk("drain_busy",    66'(a_busy),  66'(0));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
